// File: rtl/stream_demux1ton_pkg.sv
// Shared constants, select-width helper and slot state encoding for the 1-to-N stream demux.
package stream_demux_pkg;

  localparam int N_OUT_MAX = 16;
  localparam int ERRCNT_W  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Bits needed to address n channels, never less than one.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_demux1ton_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  slot_state_t   state_reg, state_next;
  logic [DW-1:0] data_reg;

  // A load while full is only possible when the slot drains on the same edge.
  always_comb begin
    state_next = state_reg;
    if (state_reg == SLOT_EMPTY) begin
      if (load) state_next = SLOT_FULL;
    end else begin
      if (load)       state_next = SLOT_FULL;
      else if (ready) state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) data_reg <= load_data;
    end
  end

  assign valid = (state_reg == SLOT_FULL);
  assign data  = data_reg;

endmodule

// File: rtl/stream_demux1ton.sv
// Registered 1-to-N stream demux; define STREAM_DEMUX_ERRCNT_EN to count dropped out-of-range beats.
module stream_demux1ton
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT = 2,
  parameter  int DW    = 8,
  localparam int SW    = sel_width(N_OUT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SW-1:0]       in_sel,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
`ifdef STREAM_DEMUX_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  output logic [N_OUT*DW-1:0] out_data
);

  logic             sel_in_range;
  logic             sel_ready;
  logic             accept;
  logic [N_OUT-1:0] load_vec;

  assign sel_in_range = (32'(in_sel) < 32'(N_OUT));

  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (32'(in_sel) == 32'(k)) sel_ready = !out_valid[k] || out_ready[k];
    end
  end

  // Out-of-range beats are always taken so the producer never wedges on them.
  assign in_ready = sel_in_range ? sel_ready : 1'b1;
  assign accept   = in_valid && in_ready;

  always_comb begin
    load_vec = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load_vec[k] = accept && (32'(in_sel) == 32'(k));
    end
  end

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_vec[gi]),
        .load_data (in_data),
        .ready     (out_ready[gi]),
        .valid     (out_valid[gi]),
        .data      (out_data[gi*DW +: DW])
      );
    end
  endgenerate

`ifdef STREAM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (accept && !sel_in_range && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_stream_demux1ton.sv
// Directed bench for stream_demux1ton: a 2-channel and a 3-channel instance.
module tb_stream_demux1ton;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-channel instance
  logic        i2_valid;
  logic        i2_ready;
  logic [7:0]  i2_data;
  logic [0:0]  i2_sel;
  logic [1:0]  o2_valid;
  logic [1:0]  o2_ready;
  logic [15:0] o2_data;

  // 3-channel instance
  logic        i3_valid;
  logic        i3_ready;
  logic [7:0]  i3_data;
  logic [1:0]  i3_sel;
  logic [2:0]  o3_valid;
  logic [2:0]  o3_ready;
  logic [23:0] o3_data;
`ifdef STREAM_DEMUX_ERRCNT_EN
  logic [7:0]  e2_cnt;
  logic [7:0]  e3_cnt;
`endif

  stream_demux1ton #(.N_OUT(2), .DW(8)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i2_valid),
    .in_ready  (i2_ready),
    .in_data   (i2_data),
    .in_sel    (i2_sel),
    .out_valid (o2_valid),
    .out_ready (o2_ready),
`ifdef STREAM_DEMUX_ERRCNT_EN
    .err_cnt   (e2_cnt),
`endif
    .out_data  (o2_data)
  );

  stream_demux1ton #(.N_OUT(3), .DW(8)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i3_valid),
    .in_ready  (i3_ready),
    .in_data   (i3_data),
    .in_sel    (i3_sel),
    .out_valid (o3_valid),
    .out_ready (o3_ready),
`ifdef STREAM_DEMUX_ERRCNT_EN
    .err_cnt   (e3_cnt),
`endif
    .out_data  (o3_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    i2_valid = 1'b1; i2_data = 8'h55; i2_sel = 1'b0; o2_ready = 2'b00;
    i3_valid = 1'b0; i3_data = 8'h00; i3_sel = 2'd0; o3_ready = 3'b000;

    // 1: reset overrides a pending handshake
    tick(); tick();
    chk("rst_out_valid2", 32'(o2_valid), 32'h0);
    chk("rst_out_data2", 32'(o2_data), 32'h0);
    chk("rst_out_valid3", 32'(o3_valid), 32'h0);
    chk("rst_out_data3", 32'(o3_data), 32'h0);
    rst = 1'b0; i2_valid = 1'b0;
    tick();
    chk("post_rst_valid2", 32'(o2_valid), 32'h0);
    for (int s = 0; s < 2; s++) begin
      i2_sel = s[0:0]; #1;
      chk($sformatf("idle_in_ready2_sel%0d", s), 32'(i2_ready), 32'h1);
    end
    for (int s = 0; s < 4; s++) begin
      i3_sel = s[1:0]; #1;
      chk($sformatf("idle_in_ready3_sel%0d", s), 32'(i3_ready), 32'h1);
    end
    $display("step 1 reset done");

    // 2: one beat per channel, consumers ready
    o2_ready = 2'b11;
    i2_valid = 1'b1; i2_data = 8'hA5; i2_sel = 1'b0; #1;
    chk("t2_in_ready_a", 32'(i2_ready), 32'h1);
    tick();
    chk("t2_valid_c1", 32'(o2_valid), 32'h1);
    chk("t2_data0_c1", 32'(o2_data[7:0]), 32'hA5);
    i2_data = 8'h3C; i2_sel = 1'b1;
    tick();
    chk("t2_valid_c2", 32'(o2_valid), 32'h2);
    chk("t2_data1_c2", 32'(o2_data[15:8]), 32'h3C);
    i2_valid = 1'b0;
    tick();
    chk("t2_valid_c3", 32'(o2_valid), 32'h0);
    $display("step 2 basic routing done");

    // 3: backpressure on channel 0
    o2_ready = 2'b10;
    i2_valid = 1'b1; i2_data = 8'h11; i2_sel = 1'b0;
    tick();
    chk("t3_valid_held", 32'(o2_valid), 32'h1);
    chk("t3_data0_11", 32'(o2_data[7:0]), 32'h11);
    i2_data = 8'h22; #1;
    chk("t3_in_ready_blocked", 32'(i2_ready), 32'h0);
    tick();
    chk("t3_valid_still", 32'(o2_valid), 32'h1);
    chk("t3_data0_stable", 32'(o2_data[7:0]), 32'h11);
    i2_data = 8'h33; i2_sel = 1'b1; #1;
    chk("t3_in_ready_sel1", 32'(i2_ready), 32'h1);
    tick();
    chk("t3_valid_both", 32'(o2_valid), 32'h3);
    chk("t3_data1_33", 32'(o2_data[15:8]), 32'h33);
    chk("t3_data0_kept", 32'(o2_data[7:0]), 32'h11);
    i2_data = 8'h22; i2_sel = 1'b0; o2_ready = 2'b11; #1;
    chk("t3_in_ready_pass", 32'(i2_ready), 32'h1);
    tick();
    chk("t3_valid_replace", 32'(o2_valid), 32'h1);
    chk("t3_data0_22", 32'(o2_data[7:0]), 32'h22);
    i2_valid = 1'b0;
    tick();
    chk("t3_valid_drained", 32'(o2_valid), 32'h0);
    $display("step 3 backpressure done");

    // 4: 16 back-to-back beats, alternating channel
    i2_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      i2_data = b; i2_sel = b[0:0]; #1;
      chk($sformatf("t4_in_ready_%0d", i), 32'(i2_ready), 32'h1);
      tick();
      chk($sformatf("t4_valid_%0d", i), 32'(o2_valid), 32'(2'b01 << b[0]));
      chk($sformatf("t4_data_%0d", i), 32'(o2_data[b[0]*8 +: 8]), 32'(b));
      $display("step 4 beat %0d sel %0d data %02h", i, b[0], b);
    end
    i2_valid = 1'b0;
    tick();
    chk("t4_valid_end", 32'(o2_valid), 32'h0);

    // 5: reset while channel 1 holds a beat
    o2_ready = 2'b01;
    i2_valid = 1'b1; i2_data = 8'h77; i2_sel = 1'b1;
    tick();
    chk("t5_valid_held", 32'(o2_valid), 32'h2);
    chk("t5_data1_77", 32'(o2_data[15:8]), 32'h77);
    i2_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; o2_ready = 2'b11;
    chk("t5_valid_cleared", 32'(o2_valid), 32'h0);
    chk("t5_data1_cleared", 32'(o2_data[15:8]), 32'h0);
    tick();
    chk("t5_never_delivered", 32'(o2_valid), 32'h0);
    $display("step 5 mid reset done");

    // 6: out-of-range beats on the 3-channel instance
    o3_ready = 3'b111;
    i3_valid = 1'b1; i3_data = 8'h09; i3_sel = 2'd2;
    tick();
    chk("t6_legal_valid", 32'(o3_valid), 32'h4);
    chk("t6_legal_data", 32'(o3_data[23:16]), 32'h09);
    i3_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      i3_data = 8'(i); #1;
      chk("t6_in_ready_oor", 32'(i3_ready), 32'h1);
      tick();
      chk("t6_no_valid", 32'(o3_valid), 32'h0);
`ifdef STREAM_DEMUX_ERRCNT_EN
      if (i == 9) chk("t6_err_cnt_10", 32'(e3_cnt), 32'd10);
`endif
    end
    i3_valid = 1'b0;
`ifdef STREAM_DEMUX_ERRCNT_EN
    chk("t6_err_cnt_sat", 32'(e3_cnt), 32'd255);
    chk("t6_err_cnt_pow2", 32'(e2_cnt), 32'd0);
`endif
    chk("t6_data_untouched", 32'(o3_data), 32'h090000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef STREAM_DEMUX_ERRCNT_EN
    chk("t6_err_cnt_rst", 32'(e3_cnt), 32'd0);
`endif
    chk("t6_data_rst", 32'(o3_data), 32'h0);
    $display("step 6 out-of-range done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux1ton.md
Name: stream_demux1ton

Overview:
- Registered 1-to-N demultiplexer: the inverse of the team's 2-to-1 select mux.
- Routes each input beat to the output chosen by its sel tag, over valid/ready handshakes.
- Each output has a one-entry holding register, so a stalled output does not block beats bound for other outputs once they are accepted.
- Sits between a single producer and N independent consumers on one clock.

Parameters:
- N_OUT, 2, number of output channels (2..16).
- DW, 8, data width in bits.
- SW, $clog2(N_OUT) (min 1), select width, derived; not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  beat accepted when in_valid && in_ready at clk edge.
- in_data  input  DW  beat payload.
- in_sel  input  SW  destination channel, sampled with in_data.
- out_valid  output  N_OUT  per-channel holding register full.
- out_ready  input  N_OUT  per-channel consumer ready.
- out_data  output  N_OUT*DW  flattened; channel k at [k*DW +: DW].
- err_cnt  output  8  present only with the optional feature (see below).

Behaviour:
- Reset (rst=1 at edge): all out_valid=0, out_data=0, err_cnt=0. rst overrides any same-cycle handshake. Mid-operation reset discards held beats without delivering them.
- Slot k states: EMPTY / FULL.
  - EMPTY -> FULL on accept with in_sel==k.
  - FULL -> EMPTY on out_valid[k]&&out_ready[k] with no new accept for k.
  - FULL stays FULL on drain + same-cycle accept for k; data is replaced by the new beat.
- in_ready is combinational on in_sel and slot state:
  - in_sel<N_OUT: in_ready = !out_valid[in_sel] || out_ready[in_sel] (pass-through when draining).
  - in_sel>=N_OUT: in_ready=1 (beat is dropped).
- No combinational path from in_data to out_data.
- Latency: accepted beat appears on out_valid/out_data the next cycle; throughput 1 beat/cycle per channel when the consumer is ready.
- out_data[k] holds stable while out_valid[k]=1 && out_ready[k]=0. Non-selected channels never change.
- Ordering preserved per channel; no ordering guarantee across channels.
- in_sel is a don't-care when in_valid=0, and in_ready may toggle then.
- Producer must hold in_data/in_sel stable while in_valid && !in_ready.

Optional Feature:
- Macro: STREAM_DEMUX_ERRCNT_EN.
- Defined:
  - err_cnt port exists.
  - Each accepted beat with in_sel>=N_OUT increments err_cnt by 1, saturating at 255. No wrap.
  - Reset clears it.
- Undefined:
  - err_cnt port and its counter are absent.
  - Out-of-range beats are still accepted and silently dropped.
- When N_OUT is a power of 2, no sel is out of range, so err_cnt stays 0.

Decomposition:
- Package stream_demux_pkg holds:
  - N_OUT_MAX=16
  - ERRCNT_W=8
  - function sel_width(n)
  - slot state enum {SLOT_EMPTY, SLOT_FULL}
- Sub-module demux_slot: one-entry register with load/drain handshake, instantiated N_OUT times in a generate loop.
- Top holds sel decode, in_ready mux and the error counter.

Test Plan:
1. Reset with in_valid=1, out_ready=0 -> all out_valid=0, out_data=0; after release, in_ready=1 for every sel.
2. N_OUT=2, DW=8, send 0xA5 sel=0 then 0x3C sel=1, both consumers ready -> out_valid[0] high with 0xA5 cycle+1; out_valid[1] high with 0x3C cycle+2; each high one cycle.
3. Backpressure: out_ready[0]=0, send 0x11 sel=0 -> slot 0 full; next beat 0x22 sel=0 sees in_ready=0.
   - Beat 0x33 sel=1 is accepted and delivered while 0x11 is held stable.
   - Raise out_ready[0] -> 0x11 drains and 0x22 is accepted the same edge; out_data[0]=0x22 next cycle.
4. Streaming: 16 back-to-back beats 0x00..0x0F alternating sel, all ready -> in_ready stays 1; each channel receives its 8 beats in order, no bubbles.
5. Reset mid-operation: slot 1 full with 0x77, out_ready[1]=0, assert rst one cycle -> out_valid[1]=0 next cycle; 0x77 is never delivered.
6. STREAM_DEMUX_ERRCNT_EN, N_OUT=3: 300 beats with sel=3 -> all accepted, no out_valid asserted, err_cnt=255 (saturated).
   - Then rst -> err_cnt=0.
   - Build without the macro -> same beats dropped silently, and the build has no err_cnt port.
